cpu_seq: RTL
============

// Module: cpu_seq
// PURPOSE
// Multi-cycle sequencer for the cpu_v1 datapath. Fetches one 32-bit instruction per
// iteration over a req/ack instruction-memory port and holds it in an instruction
// register feeding the decoder. Qualifies the decoder's register-file write into a
// single EXEC-cycle strobe and advances the PC. Halts on unsupported opcodes.
// PARAMETERS
// ADDR_W    10   PC / imem byte-address width; PC wraps modulo 2^ADDR_W
// RESET_PC  0    PC value after reset; must be word aligned (bits [1:0]=0)
// PORTS
// clk          in   1       system clock, all state on rising edge
// rst_n        in   1       asynchronous active-low reset
// run          in   1       level; 1 = sequence instructions, 0 = stop at next boundary
// imem_req     out  1       fetch request, held high until imem_ack
// imem_addr    out  ADDR_W  fetch byte address (= pc_o while imem_req)
// imem_ack     in   1       fetch complete; imem_rdata valid this cycle
// imem_rdata   in   32      fetched instruction word
// instr_o      out  32      instruction register, to decoder instr input
// dec_rf_we    in   1       decoder register-file write request
// rf_we_o      out  1       qualified register-file write strobe
// pc_o         out  ADDR_W  current PC
// halt_o       out  1       sticky: illegal opcode encountered
// state_o      out  3       FSM state encoding (debug)
// instret_o    out  32      retired-instruction count (see CONFIGURATION)
// cycles_o     out  32      cycles since reset (see CONFIGURATION)
// BEHAVIOUR
// - Reset (rst_n=0, takes effect immediately): state=IDLE(0), pc_o=RESET_PC, instr_o=0,
//   imem_req=0, rf_we_o=0, halt_o=0, counters=0. A fetch in flight is abandoned;
//   a late imem_ack after reset release is ignored outside FETCH.
// - States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, HALT=4.
// - IDLE: run=1 -> FETCH next cycle; else stay.
// - FETCH: imem_req=1, imem_addr=pc_o. ack=0 -> stay, req and addr stable.
//   ack=1 -> instr_o<=imem_rdata, -> DECODE. Same-cycle ack allowed (1-cycle FETCH).
//   run is not sampled in FETCH; an issued fetch always completes.
// - DECODE: one cycle; instr_o stable so decoder/regfile/ALU settle. -> EXEC.
// - EXEC: legal = instr_o[6:0] in {7'b0110011, 7'b0010011}.
//   legal: rf_we_o=dec_rf_we (combinational, only in EXEC); pc_o<=pc_o+4 (wraps);
//   next = run ? FETCH : IDLE.
//   illegal: rf_we_o=0, pc_o unchanged (points at faulting instr), halt_o<=1, -> HALT.
// - HALT: absorbing until reset; imem_req=0, rf_we_o=0, run ignored.
// - rf_we_o is 0 in every state except EXEC; at most one pulse per instruction.
// - Throughput: 3 cycles/instruction with zero-wait ack; +N per ack wait cycle.
// - PC wrap: pc_o = 2^ADDR_W-4 retiring -> pc_o becomes 0, no flag.
// CONFIGURATION
// CPU_SEQ_PERF_CNT_EN defined: instret_o increments by 1 at each legal EXEC cycle;
//   cycles_o increments every cycle out of reset (including HALT); both 32-bit, wrap.
// CPU_SEQ_PERF_CNT_EN undefined: instret_o and cycles_o tied to 0, no counter flops.
// TESTING
// 1. Reset, run=1, imem returns ADDI x1,x0,5 (0x00500093) with ack same cycle ->
//    imem_addr=0, rf_we_o pulses once on cycle 3, pc_o=4 after, fetch of addr 4 next.
// 2. ack delayed 4 cycles -> imem_req/imem_addr stable for 5 cycles, instr_o loaded
//    only on ack cycle, rf_we_o pulses exactly once.
// 3. Instr 0x0000007F (illegal) at pc 8 -> halt_o=1, state_o=4, pc_o=8, no rf_we_o,
//    imem_req stays 0 with run=1 for 20 cycles.
// 4. run dropped during DECODE -> instruction retires, state IDLE, pc_o advanced by 4;
//    run reasserted -> fetch resumes at new pc_o.
// 5. ADDR_W=4, program of legal instrs from pc 12 -> after retire pc_o=0 (wrap).
// 6. rst_n low mid-FETCH -> imem_req=0 immediately, all outputs at reset values;
//    with CPU_SEQ_PERF_CNT_EN, 10 retired instrs -> instret_o=10, cycles_o>=30.

Source files
------------

// File: rtl/cpu_seq.sv
// cpu_seq: multi-cycle fetch / decode / exec sequencer for the cpu_v1 datapath.
// Fetches one instruction per iteration over a req/ack port, holds it in the
// instruction register, turns the decoder's write request into one EXEC-cycle
// strobe, advances the PC and halts on unsupported opcodes.
// Optional feature macro: CPU_SEQ_PERF_CNT_EN (retired-instruction and cycle counters).
// Ports:
//   clk, rst_n              clock, async active-low reset
//   run                     level; 1 = sequence, 0 = stop at next instruction boundary
//   imem_req/addr/ack/rdata instruction fetch port (addr = pc_o while req)
//   instr_o                 instruction register, to decoder
//   dec_rf_we / rf_we_o     decoder write request / qualified write strobe (EXEC only)
//   pc_o, halt_o, state_o   PC, sticky illegal-opcode flag, FSM state (debug)
//   instret_o, cycles_o     performance counters (0 when the feature is disabled)
module cpu_seq #(
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       instr_o,
   input  logic              dec_rf_we,
   output logic              rf_we_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic              halt_o,
   output logic [2:0]        state_o,
   output logic [31:0]       instret_o,
   output logic [31:0]       cycles_o
);

   localparam int unsigned INSTR_W = 32;
   localparam logic [6:0]  OP_REG  = 7'b0110011;
   localparam logic [6:0]  OP_IMM  = 7'b0010011;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [ADDR_W-1:0]    r_pc, w_pc_nxt;
   logic [INSTR_W-1:0]   r_instr, w_instr_nxt;
   logic                 r_halt, w_halt_nxt;
   logic                 w_legal;

   // Only register-register and register-immediate ALU ops are supported.
   assign w_legal = (r_instr[6:0] == OP_REG) || (r_instr[6:0] == OP_IMM);

   // State and datapath registers; reset abandons any fetch in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_pc    <= ADDR_W'(RESET_PC);
         r_instr <= '0;
         r_halt  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_instr <= w_instr_nxt;
         r_halt  <= w_halt_nxt;
      end
   end

   // Next-state logic; imem_req and rf_we_o are decoded from the state register.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_instr_nxt = r_instr;
      w_halt_nxt  = r_halt;
      imem_req    = 1'b0;
      rf_we_o     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (run) w_state_nxt = S_FETCH;
         end
         S_FETCH: begin
            // run is not sampled here: an issued fetch always completes.
            imem_req = 1'b1;
            if (imem_ack) begin
               w_instr_nxt = imem_rdata;
               w_state_nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            w_state_nxt = S_EXEC;
         end
         S_EXEC: begin
            if (w_legal) begin
               rf_we_o     = dec_rf_we;
               w_pc_nxt    = r_pc + ADDR_W'(4);
               w_state_nxt = run ? S_FETCH : S_IDLE;
            end else begin
               // PC is left pointing at the faulting instruction.
               w_halt_nxt  = 1'b1;
               w_state_nxt = S_HALT;
            end
         end
         S_HALT: begin
            w_state_nxt = S_HALT;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign imem_addr = r_pc;
   assign pc_o      = r_pc;
   assign instr_o   = r_instr;
   assign halt_o    = r_halt;
   assign state_o   = r_state;

`ifdef CPU_SEQ_PERF_CNT_EN
   localparam int unsigned CNT_W = 32;

   logic [CNT_W-1:0] r_instret;
   logic [CNT_W-1:0] r_cycles;

   // Free-running cycle counter and retired-instruction counter, both wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instret <= '0;
         r_cycles  <= '0;
      end else begin
         r_cycles <= r_cycles + CNT_W'(1);
         if ((r_state == S_EXEC) && w_legal) r_instret <= r_instret + CNT_W'(1);
      end
   end

   assign instret_o = r_instret;
   assign cycles_o  = r_cycles;
`else
   assign instret_o = '0;
   assign cycles_o  = '0;
`endif

endmodule
